// File: rtl/triumph_pkg.sv
// Shared definitions for the triumph fetch path: data width, fetch FSM states,
// the NOP word used for error responses and the fetch address check.
package triumph_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RISCV_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } fetch_state_e;

    // A fetch is bad when it is not word aligned or lies beyond the array.
    function automatic logic fetch_addr_bad(input logic [XLEN-1:0] addr,
                                            input int unsigned idx_bits);
        return (addr[1:0] != 2'b00) || ((addr >> (idx_bits + 32'd2)) != {XLEN{1'b0}});
    endfunction

endpackage

// File: rtl/triumph_instr_mem_if.sv
// Instruction fetch handshake (req/gnt/rvalid) between the IF stage (master)
// and an instruction memory responder (slave).
interface triumph_instr_mem_if;
    import triumph_pkg::*;

    logic            instr_req;
    logic [XLEN-1:0] instr_addr;
    logic            instr_gnt;
    logic            instr_rvalid;
    logic [XLEN-1:0] instr_rdata;
    logic            instr_err;

    modport master (
        output instr_req,
        output instr_addr,
        input  instr_gnt,
        input  instr_rvalid,
        input  instr_rdata,
        input  instr_err
    );

    modport slave (
        input  instr_req,
        input  instr_addr,
        output instr_gnt,
        output instr_rvalid,
        output instr_rdata,
        output instr_err
    );

endinterface

// File: rtl/triumph_sp_ram.sv
// One-read one-write synchronous word array; a read and a write to the same
// word in one cycle return the old contents.
module triumph_sp_ram
    import triumph_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rd_en_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [XLEN-1:0]  rd_data_o,
    input  logic             we_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [XLEN-1:0]  wr_data_i
);

    logic [XLEN-1:0] mem_r [DEPTH];
    logic [XLEN-1:0] rd_data_r;

    // Word write port; contents are never cleared so they survive reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_r[wr_idx_i] <= wr_data_i;
        end
    end

    // Registered read port; non-blocking update gives read-before-write.
    always_ff @(posedge clk_i) begin
        if (rd_en_i) begin
            rd_data_r <= mem_r[rd_idx_i];
        end
    end

    assign rd_data_o = rd_data_r;

endmodule

// File: rtl/triumph_instr_mem.sv
// Instruction memory responder: grants fetches, waits WAIT_CYCLES, then returns
// one word (or an error NOP) per grant. A side-band port fills the array.
module triumph_instr_mem
    import triumph_pkg::*;
#(
    parameter int unsigned     DEPTH_WORDS = 1024,
    parameter int unsigned     WAIT_CYCLES = 0,
    parameter logic [XLEN-1:0] ERR_DATA    = RISCV_NOP
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    triumph_instr_mem_if.slave  fetch,
    input  logic                load_we_i,
    input  logic [XLEN-1:0]     load_addr_i,
    input  logic [XLEN-1:0]     load_wdata_i
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    fetch_state_e     state_r;
    logic [3:0]       cnt_r;
    logic [IDX_W-1:0] idx_r;
    logic             bad_r;
    logic             rvalid_r;
    logic             err_r;

    logic             gnt_s;
    logic             req_bad_s;
    logic             enter_resp_s;
    logic [IDX_W-1:0] rd_idx_s;
    logic             rd_bad_s;
    logic             rd_en_s;
    logic             load_en_s;
    logic [XLEN-1:0]  ram_rdata_s;

    // Grant, and select which address feeds the array read that sets up RESP.
    always_comb begin
        gnt_s        = 1'b0;
        req_bad_s    = 1'b0;
        enter_resp_s = 1'b0;
        rd_idx_s     = {IDX_W{1'b0}};
        rd_bad_s     = 1'b0;
        rd_en_s      = 1'b0;
        load_en_s    = 1'b0;

        gnt_s     = fetch.instr_req && ((state_r == ST_IDLE) || (state_r == ST_RESP));
        req_bad_s = fetch_addr_bad(fetch.instr_addr, IDX_W);

        if (state_r == ST_WAIT) begin
            rd_idx_s     = idx_r;
            rd_bad_s     = bad_r;
            enter_resp_s = (cnt_r == 4'd0);
        end else begin
            rd_idx_s     = fetch.instr_addr[IDX_W+1:2];
            rd_bad_s     = req_bad_s;
            enter_resp_s = gnt_s && (WAIT_CYCLES == 32'd0);
        end

        // Error responses never touch the array.
        rd_en_s   = enter_resp_s && !rd_bad_s;
        load_en_s = load_we_i && ((load_addr_i >> (IDX_W + 32'd2)) == {XLEN{1'b0}});
    end

    // Fetch FSM with wait counter, latched request and registered response flags.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 4'd0;
            idx_r    <= {IDX_W{1'b0}};
            bad_r    <= 1'b0;
            rvalid_r <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            rvalid_r <= enter_resp_s;
            err_r    <= enter_resp_s && rd_bad_s;
            case (state_r)
                ST_IDLE, ST_RESP: begin
                    if (gnt_s) begin
                        idx_r <= fetch.instr_addr[IDX_W+1:2];
                        bad_r <= req_bad_s;
                        if (WAIT_CYCLES == 32'd0) begin
                            state_r <= ST_RESP;
                        end else begin
                            state_r <= ST_WAIT;
                            cnt_r   <= 4'(WAIT_CYCLES - 32'd1);
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == 4'd0) begin
                        state_r <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    triumph_sp_ram #(
        .DEPTH (DEPTH_WORDS),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk_i     (clk_i),
        .rd_en_i   (rd_en_s),
        .rd_idx_i  (rd_idx_s),
        .rd_data_o (ram_rdata_s),
        .we_i      (load_en_s),
        .wr_idx_i  (load_addr_i[IDX_W+1:2]),
        .wr_data_i (load_wdata_i)
    );

    assign fetch.instr_gnt    = gnt_s;
    assign fetch.instr_rvalid = rvalid_r;
    assign fetch.instr_err    = err_r;
    assign fetch.instr_rdata  = !rvalid_r ? {XLEN{1'b0}} : (err_r ? ERR_DATA : ram_rdata_s);

endmodule

// File: tb/tb_triumph_instr_mem.sv
// Bench for triumph_instr_mem: three instances (0, 3 and 5 wait states) share
// clock, reset and load port; responses are checked against a scoreboard.
module tb_triumph_instr_mem;

    typedef struct packed {
        logic [31:0] cyc;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_we;
    logic [31:0] load_addr;
    logic [31:0] load_wdata;
    logic [31:0] cyc = 32'd0;
    logic [31:0] model [1024];
    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        q2[$];
    int          n_checks = 0;
    int          n_fails  = 0;

    triumph_instr_mem_if f0 ();
    triumph_instr_mem_if f1 ();
    triumph_instr_mem_if f2 ();

    triumph_instr_mem #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .fetch(f0),
        .load_we_i(load_we), .load_addr_i(load_addr), .load_wdata_i(load_wdata));
    triumph_instr_mem #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n), .fetch(f1),
        .load_we_i(load_we), .load_addr_i(load_addr), .load_wdata_i(load_wdata));
    triumph_instr_mem #(.DEPTH_WORDS(1024), .WAIT_CYCLES(5)) u_dut5 (
        .clk_i(clk), .rst_ni(rst_n), .fetch(f2),
        .load_we_i(load_we), .load_addr_i(load_addr), .load_wdata_i(load_wdata));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%h expected 0x%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, {31'd0, obs}, {31'd0, exp});
    endtask

    function automatic logic [31:0] wait_of(input int id);
        case (id)
            0:       return 32'd0;
            1:       return 32'd3;
            default: return 32'd5;
        endcase
    endfunction

    function automatic logic get_gnt(input int id);
        case (id)
            0:       return f0.instr_gnt;
            1:       return f1.instr_gnt;
            default: return f2.instr_gnt;
        endcase
    endfunction

    function automatic exp_t mk(input logic [31:0] c, input logic [31:0] a);
        exp_t e;
        logic [9:0] ix;
        e.cyc  = c;
        e.err  = (a[1:0] != 2'b00) || (a >= 32'h0000_1000);
        ix     = a[11:2];
        e.data = e.err ? 32'h0000_0013 : model[ix];
        return e;
    endfunction

    task automatic push(input int id, input exp_t e);
        case (id)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic drive(input int id, input logic rq, input logic [31:0] a);
        case (id)
            0:       begin f0.instr_req = rq; f0.instr_addr = a; end
            1:       begin f1.instr_req = rq; f1.instr_addr = a; end
            default: begin f2.instr_req = rq; f2.instr_addr = a; end
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One cycle of fetch stimulus on one instance; expected grants go to the scoreboard.
    task automatic req_cycle(input int id, input logic rq, input logic [31:0] a,
                             input logic exp_g, input string tag);
        drive(id, rq, a);
        @(negedge clk);
        chk1(tag, get_gnt(id), exp_g);
        if (exp_g) push(id, mk(cyc + 32'd1 + wait_of(id), a));
        step();
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        load_we    = 1'b1;
        load_addr  = a;
        load_wdata = d;
        step();
        if (a < 32'h0000_1000) model[a[11:2]] = d;
        load_we = 1'b0;
    endtask

    task automatic mon(input int id, input logic rv, input logic er, input logic [31:0] rd);
        exp_t e;
        logic have;
        if (rv === 1'b1) begin
            have = 1'b0;
            e    = '0;
            case (id)
                0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
            endcase
            chk1($sformatf("resp_expected_d%0d", id), have, 1'b1);
            if (have) begin
                chk($sformatf("resp_cycle_d%0d", id), cyc, e.cyc);
                chk1($sformatf("resp_err_d%0d", id), er, e.err);
                chk($sformatf("resp_rdata_d%0d", id), rd, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, f0.instr_rvalid, f0.instr_err, f0.instr_rdata);
        mon(1, f1.instr_rvalid, f1.instr_err, f1.instr_rdata);
        mon(2, f2.instr_rvalid, f2.instr_err, f2.instr_rdata);
    end

    initial begin
        rst_n      = 1'b0;
        load_we    = 1'b0;
        load_addr  = 32'd0;
        load_wdata = 32'd0;
        drive(0, 1'b1, 32'd0);
        drive(1, 1'b1, 32'd0);
        drive(2, 1'b1, 32'd0);
        step();

        // Reset held with req high; the preload happens while in reset.
        for (int i = 0; i < 4; i++) begin
            load_we    = 1'b1;
            load_addr  = 32'(i * 4);
            load_wdata = 32'h0000_00A0 + 32'(i);
            @(negedge clk);
            chk1("rst_rvalid", f0.instr_rvalid, 1'b0);
            chk("rst_rdata", f0.instr_rdata, 32'd0);
            chk1("rst_err", f0.instr_err, 1'b0);
            chk1("rst_rvalid_d5", f2.instr_rvalid, 1'b0);
            step();
            model[i] = 32'h0000_00A0 + 32'(i);
        end
        load_we = 1'b0;
        rst_n   = 1'b1;
        drive(0, 1'b0, 32'd0);
        drive(1, 1'b0, 32'd0);
        drive(2, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("post_rst_rvalid", f0.instr_rvalid, 1'b0);
            step();
        end

        // Back-to-back fetches, zero wait states.
        for (int i = 0; i < 4; i++) req_cycle(0, 1'b1, 32'(i * 4), 1'b1, "b2b_gnt");
        req_cycle(0, 1'b0, 32'd0, 1'b0, "b2b_idle");
        step();

        // Out-of-range load is dropped; the last legal word is fetchable.
        load(32'h0000_1000, 32'hDEAD_DEAD);
        load(32'h0000_0FFC, 32'h1234_5678);
        req_cycle(0, 1'b1, 32'h0000_0FFC, 1'b1, "top_word_gnt");
        req_cycle(0, 1'b1, 32'h0000_0000, 1'b1, "word0_gnt");
        req_cycle(0, 1'b0, 32'd0, 1'b0, "top_idle");
        step();

        // Three wait states: grant, three blocked cycles, then the response.
        req_cycle(1, 1'b1, 32'h0000_0008, 1'b1, "w3_gnt");
        for (int i = 0; i < 3; i++) req_cycle(1, 1'b1, 32'h0000_0008, 1'b0, "w3_wait_gnt");
        req_cycle(1, 1'b0, 32'd0, 1'b0, "w3_resp_gnt");
        req_cycle(1, 1'b1, 32'h0000_0006, 1'b1, "w3_err_gnt");
        for (int i = 0; i < 3; i++) req_cycle(1, 1'b1, 32'h0000_0006, 1'b0, "w3_err_wait");
        req_cycle(1, 1'b0, 32'd0, 1'b0, "w3_err_resp");
        step();

        // Error responses: misaligned, just past the end, high address bit.
        req_cycle(0, 1'b1, 32'h0000_0006, 1'b1, "err_mis_gnt");
        req_cycle(0, 1'b1, 32'h0000_1000, 1'b1, "err_oor_gnt");
        req_cycle(0, 1'b1, 32'h8000_0000, 1'b1, "err_hi_gnt");
        req_cycle(0, 1'b0, 32'd0, 1'b0, "err_idle");
        step();

        // Load after the read cycle, then a load in the same cycle as the read.
        req_cycle(0, 1'b1, 32'h0000_0004, 1'b1, "rbw_gnt");
        load_we    = 1'b1;
        load_addr  = 32'h0000_0004;
        load_wdata = 32'h0000_BEEF;
        req_cycle(0, 1'b0, 32'd0, 1'b0, "rbw_load");
        model[1]   = 32'h0000_BEEF;
        load_addr  = 32'h0000_0008;
        load_wdata = 32'h0000_C0DE;
        req_cycle(0, 1'b1, 32'h0000_0008, 1'b1, "rbw_same_gnt");
        model[2]   = 32'h0000_C0DE;
        load_we    = 1'b0;
        req_cycle(0, 1'b1, 32'h0000_0004, 1'b1, "rbw_refetch4");
        req_cycle(0, 1'b1, 32'h0000_0008, 1'b1, "rbw_refetch8");
        req_cycle(0, 1'b0, 32'd0, 1'b0, "rbw_idle");
        repeat (3) step();

        // Reset two cycles into a five-wait-state fetch drops it.
        req_cycle(2, 1'b1, 32'h0000_000C, 1'b1, "rst_mid_gnt");
        req_cycle(2, 1'b0, 32'd0, 1'b0, "rst_mid_wait");
        rst_n = 1'b0;
        q2.delete();
        req_cycle(2, 1'b0, 32'd0, 1'b0, "rst_mid_rst");
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk1("rst_mid_no_rvalid", f2.instr_rvalid, 1'b0);
            step();
        end
        req_cycle(2, 1'b1, 32'h0000_0000, 1'b1, "after_rst_gnt");
        for (int i = 0; i < 6; i++) req_cycle(2, 1'b0, 32'd0, 1'b0, "after_rst_wait");
        req_cycle(0, 1'b1, 32'h0000_000C, 1'b1, "after_rst_d0_gnt");
        req_cycle(0, 1'b0, 32'd0, 1'b0, "after_rst_d0_idle");

        repeat (8) step();
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        chk("q2_drained", 32'(q2.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
